// File: rtl/core_pkg.sv
// Shared types, widths and PC helpers for the branch prediction / resolution stage.
package core_pkg;

   localparam int XLEN     = 64;
   localparam int IDX_BITS = 6;
   localparam int TAG_BITS = 12;
   localparam int ENTRIES  = 1 << IDX_BITS;

   typedef logic [1:0]          ctr_t;
   typedef logic [IDX_BITS-1:0] idx_t;
   typedef logic [TAG_BITS-1:0] tag_t;
   typedef logic [XLEN-1:0]     xlen_t;

   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b10;
   localparam ctr_t CTR_ST  = 2'b11;

   // Table index: word-aligned PC bits just above the byte offset.
   function automatic idx_t pc_idx(input xlen_t pc);
      return pc[IDX_BITS+1:2];
   endfunction

   // BTB tag: the PC bits directly above the index.
   function automatic tag_t pc_tag(input xlen_t pc);
      return pc[IDX_BITS+2 +: TAG_BITS];
   endfunction

   // 2-bit saturating counter step toward the resolved outcome.
   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      ctr_t n;
      n = c;
      if (taken && c != CTR_ST)
         n = c + 2'd1;
      else if (!taken && c != CTR_SNT)
         n = c - 2'd1;
      return n;
   endfunction

endpackage

// File: rtl/bht_ctr_table.sv
// Bimodal 2-bit saturating counter array: one combinational read port, one update port.
module bht_ctr_table
   import core_pkg::*;
#(
   parameter ctr_t CTR_INIT = CTR_WNT
) (
   input  logic clk,
   input  logic rstn,
   input  idx_t rd_idx_i,
   output ctr_t rd_ctr_o,
   input  logic upd_en_i,
   input  idx_t upd_idx_i,
   input  logic upd_taken_i
);

   ctr_t ctr_q [ENTRIES];

   // Read returns the flopped value, so a same-cycle update is not visible until the next cycle.
   assign rd_ctr_o = ctr_q[rd_idx_i];

   // Counter storage: cleared to the initial bias on reset, stepped toward the outcome on update.
   // NOTE: every counter is reset because prediction reads them directly with no valid bit to mask garbage.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
      end else if (upd_en_i) begin
         ctr_q[upd_idx_i] <= ctr_next(ctr_q[upd_idx_i], upd_taken_i);
      end
   end

endmodule

// File: rtl/branch_resolve_bht.sv
// IF-stage branch prediction (bimodal counters + direct-mapped BTB) and EX-stage resolution
// with a registered one-cycle redirect on mispredict.
module branch_resolve_bht
   import core_pkg::*;
#(
   parameter ctr_t CTR_INIT = CTR_WNT
) (
   input  logic        clk,
   input  logic        rstn,
   input  xlen_t       if_pc,
   output logic        pred_taken,
   output xlen_t       pred_target,
   input  logic        ex_valid,
   input  logic        ex_stall,
   input  logic        ex_is_branch,
   input  logic        ex_is_jump,
   input  xlen_t       ex_pc,
   input  logic        ex_pred_taken,
   input  xlen_t       ex_pred_target,
   input  xlen_t       ex_target,
   input  logic        br_taken,
   output logic        redirect_valid,
   output xlen_t       redirect_pc,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispred
);

   logic  btb_valid_q  [ENTRIES];
   tag_t  btb_tag_q    [ENTRIES];
   xlen_t btb_target_q [ENTRIES];

   logic        redirect_valid_q, redirect_valid_d;
   xlen_t       redirect_pc_q, redirect_pc_d;
   logic [31:0] stat_branches_q, stat_branches_d;
   logic [31:0] stat_mispred_q, stat_mispred_d;

   idx_t if_idx, ex_idx;
   ctr_t if_ctr;
   logic btb_hit, resolve, actual, mispredict;

   assign if_idx = pc_idx(if_pc);
   assign ex_idx = pc_idx(ex_pc);

   bht_ctr_table #(.CTR_INIT(CTR_INIT)) u_ctr_table (
      .clk         (clk),
      .rstn        (rstn),
      .rd_idx_i    (if_idx),
      .rd_ctr_o    (if_ctr),
      .upd_en_i    (resolve),
      .upd_idx_i   (ex_idx),
      .upd_taken_i (actual)
   );

   // IF lookup: zero-cycle read of the flopped tables; target forced to 0 on a not-taken prediction.
   always_comb begin
      btb_hit     = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == pc_tag(if_pc));
      pred_taken  = btb_hit && if_ctr[1];
      pred_target = pred_taken ? btb_target_q[if_idx] : '0;
   end

   // EX resolution: wrong-path instructions (behind a live redirect) and stalled cycles are ignored.
   always_comb begin
      resolve    = ex_valid && !ex_stall && (ex_is_branch || ex_is_jump) && !redirect_valid_q;
      actual     = ex_is_jump || br_taken;
      mispredict = resolve && ((actual != ex_pred_taken) ||
                               (actual && (ex_pred_target != ex_target)));

      redirect_valid_d = mispredict;
      redirect_pc_d    = redirect_pc_q;
      if (mispredict)
         redirect_pc_d = actual ? ex_target : ex_pc + XLEN'(4);

      stat_branches_d = stat_branches_q;
      if (resolve && stat_branches_q != 32'hFFFF_FFFF)
         stat_branches_d = stat_branches_q + 32'd1;

      stat_mispred_d = stat_mispred_q;
      if (mispredict && stat_mispred_q != 32'hFFFF_FFFF)
         stat_mispred_d = stat_mispred_q + 32'd1;
   end

   // BTB valid bits: cleared on reset, set by any taken resolve; not-taken never invalidates.
   // NOTE: only the valid bits need reset; tags and targets are masked by valid and stay reset-free.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < ENTRIES; i++) btb_valid_q[i] <= 1'b0;
      end else if (resolve && actual) begin
         btb_valid_q[ex_idx] <= 1'b1;
      end
   end

   // BTB tag/target payload: overwritten on a taken resolve, aliasing entries simply replace.
   always_ff @(posedge clk) begin
      if (resolve && actual) begin
         btb_tag_q[ex_idx]    <= pc_tag(ex_pc);
         btb_target_q[ex_idx] <= ex_target;
      end
   end

   // Redirect pulse and statistics registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         stat_branches_q  <= '0;
         stat_mispred_q   <= '0;
      end else begin
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         stat_branches_q  <= stat_branches_d;
         stat_mispred_q   <= stat_mispred_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign stat_branches  = stat_branches_q;
   assign stat_mispred   = stat_mispred_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed, table-driven bench for branch_resolve_bht plus hand sequences for wrong-path,
// stall and asynchronous reset behaviour.
module tb_branch_resolve_bht;

   logic        clk;
   logic        rstn;
   logic [63:0] if_pc;
   logic        pred_taken;
   logic [63:0] pred_target;
   logic        ex_valid, ex_stall, ex_is_branch, ex_is_jump;
   logic [63:0] ex_pc, ex_pred_target, ex_target;
   logic        ex_pred_taken, br_taken;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [31:0] stat_branches, stat_mispred;

   branch_resolve_bht dut (
      .clk            (clk),
      .rstn           (rstn),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_stall       (ex_stall),
      .ex_is_branch   (ex_is_branch),
      .ex_is_jump     (ex_is_jump),
      .ex_pc          (ex_pc),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .ex_target      (ex_target),
      .br_taken       (br_taken),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stat_branches  (stat_branches),
      .stat_mispred   (stat_mispred)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [63:0] if_pc;
      logic        valid, br, jmp;
      logic [63:0] ex_pc;
      logic        ptk;
      logic [63:0] ptgt, tgt;
      logic        brt;
      logic        exp_pt;
      logic [63:0] exp_ptgt;
      logic        exp_rv;
      logic [63:0] exp_rpc;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] exp_br = 0;
   logic [31:0] exp_mp = 0;

   function automatic vec_t mk(input logic [63:0] ipc, input logic v, b, j,
                               input logic [63:0] epc, input logic pt,
                               input logic [63:0] ptg, tg, input logic bt,
                               input logic ept, input logic [63:0] eptg,
                               input logic erv, input logic [63:0] erpc);
      vec_t r;
      r.if_pc = ipc; r.valid = v; r.br = b; r.jmp = j; r.ex_pc = epc; r.ptk = pt;
      r.ptgt = ptg; r.tgt = tg; r.brt = bt; r.exp_pt = ept; r.exp_ptgt = eptg;
      r.exp_rv = erv; r.exp_rpc = erpc;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v, input logic stall);
      if_pc          = v.if_pc;
      ex_valid       = v.valid;
      ex_stall       = stall;
      ex_is_branch   = v.br;
      ex_is_jump     = v.jmp;
      ex_pc          = v.ex_pc;
      ex_pred_taken  = v.ptk;
      ex_pred_target = v.ptgt;
      ex_target      = v.tgt;
      br_taken       = v.brt;
   endtask

   task automatic go_idle();
      ex_valid = 1'b0; ex_stall = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
      ex_pc = '0; ex_pred_taken = 1'b0; ex_pred_target = '0; ex_target = '0; br_taken = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_stats(input string tag);
      check({tag, " stat_branches"}, 64'(stat_branches), 64'(exp_br));
      check({tag, " stat_mispred"},  64'(stat_mispred),  64'(exp_mp));
   endtask

   task automatic check_pred(input string tag, input logic pt, input logic [63:0] ptg);
      check({tag, " pred_taken"},  64'(pred_taken), 64'(pt));
      check({tag, " pred_target"}, pred_target, ptg);
   endtask

   initial begin
      vec_t v;
      // Test 1: reset state lookup
      vecs.push_back(mk('h1000, 0,0,0, 'h0,    0,'h0,   'h0,   0, 0,'h0,    0,'h0));
      // Test 2: BEQ taken, predicted not-taken -> redirect to target; ctr 01->10
      vecs.push_back(mk('h1000, 1,1,0, 'h1000, 0,'h0,   'h1040,1, 0,'h0,    1,'h1040));
      vecs.push_back(mk('h1000, 0,0,0, 'h0,    0,'h0,   'h0,   0, 1,'h1040, 0,'h1040));
      // Test 3: not-taken after taken prediction -> pc+4; ctr 10->01
      vecs.push_back(mk('h1000, 1,1,0, 'h1000, 1,'h1040,'h1040,0, 1,'h1040, 1,'h1004));
      vecs.push_back(mk('h1000, 0,0,0, 'h0,    0,'h0,   'h0,   0, 0,'h0,    0,'h1004));
      // three taken: 01->10->11->11
      vecs.push_back(mk('h1000, 1,1,0, 'h1000, 0,'h0,   'h1040,1, 0,'h0,    1,'h1040));
      vecs.push_back(mk('h1000, 1,1,0, 'h1000, 1,'h1040,'h1040,1, 1,'h1040, 0,'h1040));
      vecs.push_back(mk('h1000, 1,1,0, 'h1000, 1,'h1040,'h1040,1, 1,'h1040, 0,'h1040));
      // not-taken from saturated 11 -> 10, still predicts taken
      vecs.push_back(mk('h1000, 1,1,0, 'h1000, 1,'h1040,'h1040,0, 1,'h1040, 1,'h1004));
      vecs.push_back(mk('h1000, 0,0,0, 'h0,    0,'h0,   'h0,   0, 1,'h1040, 0,'h1004));
      // 10->01->00->00 (saturates low)
      vecs.push_back(mk('h1000, 1,1,0, 'h1000, 1,'h1040,'h1040,0, 1,'h1040, 1,'h1004));
      vecs.push_back(mk('h1000, 1,1,0, 'h1000, 0,'h0,   'h1040,0, 0,'h0,    0,'h1004));
      vecs.push_back(mk('h1000, 1,1,0, 'h1000, 0,'h0,   'h1040,0, 0,'h0,    0,'h1004));
      // 00->01, still not taken, then 01->10 predicts taken again
      vecs.push_back(mk('h1000, 1,1,0, 'h1000, 0,'h0,   'h1040,1, 0,'h0,    1,'h1040));
      vecs.push_back(mk('h1000, 0,0,0, 'h0,    0,'h0,   'h0,   0, 0,'h0,    0,'h1040));
      vecs.push_back(mk('h1000, 1,1,0, 'h1000, 0,'h0,   'h1040,1, 0,'h0,    1,'h1040));
      vecs.push_back(mk('h1000, 0,0,0, 'h0,    0,'h0,   'h0,   0, 1,'h1040, 0,'h1040));
      // Test 4: JALR at 0x2000 (aliases idx 0), target mismatch, comparator 0 but jump forces taken
      vecs.push_back(mk('h2000, 1,0,1, 'h2000, 1,'h3000,'h3008,0, 0,'h0,    1,'h3008));
      vecs.push_back(mk('h2000, 0,0,0, 'h0,    0,'h0,   'h0,   0, 1,'h3008, 0,'h3008));
      vecs.push_back(mk('h1000, 0,0,0, 'h0,    0,'h0,   'h0,   0, 0,'h0,    0,'h3008));
      // Test 6a: 0x1100 aliases idx 0 with a new tag and overwrites the entry
      vecs.push_back(mk('h1100, 1,1,0, 'h1100, 0,'h0,   'h1200,1, 0,'h0,    1,'h1200));
      vecs.push_back(mk('h1100, 0,0,0, 'h0,    0,'h0,   'h0,   0, 1,'h1200, 0,'h1200));
      vecs.push_back(mk('h2000, 0,0,0, 'h0,    0,'h0,   'h0,   0, 0,'h0,    0,'h1200));

      rstn  = 1'b0;
      if_pc = 'h1000;
      go_idle();
      #12;
      rstn = 1'b1;
      tick();

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         v   = vecs[i];
         tag = $sformatf("v%0d", i);
         drive(v, 1'b0);
         #3;
         check_pred(tag, v.exp_pt, v.exp_ptgt);
         tick();
         if (v.valid && (v.br || v.jmp)) begin
            exp_br++;
            if (v.exp_rv) exp_mp++;
         end
         check({tag, " redirect_valid"}, 64'(redirect_valid), 64'(v.exp_rv));
         check({tag, " redirect_pc"}, redirect_pc, v.exp_rpc);
         check_stats(tag);
         if (v.exp_rv) begin
            go_idle();
            tick();
            check({tag, " pulse_end redirect_valid"}, 64'(redirect_valid), 64'd0);
            check({tag, " pulse_end redirect_pc"}, redirect_pc, v.exp_rpc);
            check_stats({tag, " pulse_end"});
         end
      end

      // Test 5: mispredict, then a wrong-path branch while redirect is high, then a stalled resolve
      drive(mk('h1100, 1,1,0, 'h1100, 0,'h0,'h1200,1, 0,'h0,0,'h0), 1'b0);
      tick();
      exp_br++; exp_mp++;
      check("wp setup redirect_valid", 64'(redirect_valid), 64'd1);
      check("wp setup redirect_pc", redirect_pc, 64'h1200);
      drive(mk('h1100, 1,1,0, 'h1100, 1,'h1200,'h1200,0, 0,'h0,0,'h0), 1'b0);
      tick();
      check("wrong_path redirect_valid", 64'(redirect_valid), 64'd0);
      check("wrong_path redirect_pc", redirect_pc, 64'h1200);
      check_stats("wrong_path");
      drive(mk('h1100, 1,1,0, 'h1100, 1,'h1200,'h1200,0, 0,'h0,0,'h0), 1'b1);
      tick();
      check("stall redirect_valid", 64'(redirect_valid), 64'd0);
      check_stats("stall");
      go_idle();
      #3;
      check_pred("after_stall", 1'b1, 64'h1200);

      // Test 6b: async reset in the middle of a redirect pulse
      drive(mk('h1100, 1,1,0, 'h1100, 0,'h0,'h1300,1, 0,'h0,0,'h0), 1'b0);
      tick();
      check("pre_reset redirect_valid", 64'(redirect_valid), 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      exp_br = 0; exp_mp = 0;
      check("async_reset redirect_valid", 64'(redirect_valid), 64'd0);
      check("async_reset redirect_pc", redirect_pc, 64'd0);
      check_stats("async_reset");
      check_pred("async_reset", 1'b0, 64'h0);
      go_idle();
      @(negedge clk);
      rstn = 1'b1;
      tick();
      #3;
      check_pred("post_reset", 1'b0, 64'h0);
      // counters reinitialised to weakly not-taken: one taken resolve flips the prediction
      drive(mk('h1100, 1,1,0, 'h1100, 0,'h0,'h1200,1, 0,'h0,0,'h0), 1'b0);
      tick();
      exp_br++; exp_mp++;
      check("post_reset redirect_pc", redirect_pc, 64'h1200);
      check_stats("post_reset");
      go_idle();
      tick();
      #3;
      check_pred("post_reset trained", 1'b1, 64'h1200);
      drive(mk('h1100, 1,1,0, 'h1100, 1,'h1200,'h1200,0, 0,'h0,0,'h0), 1'b0);
      tick();
      exp_br++; exp_mp++;
      check("post_reset nt redirect_pc", redirect_pc, 64'h1104);
      go_idle();
      tick();
      #3;
      check_pred("post_reset nt", 1'b0, 64'h0);
      check_stats("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
